// File: rtl/adder_operand_loader.sv
// Purpose : gathers four serial operands and hands them to the adder controller as one stable parallel set.
// Latency : go pulses the cycle after the 4th transfer; WAIT begins the cycle after that.
// Backpr. : in_ready is low through GO and WAIT until a done rising edge (or a watchdog abort) reopens collection.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready  serial operand stream (valid/ready)
//   go                     one-cycle start pulse to the controller
//   a_out..d_out           operand set, changes only when a full set lands
//   done                   controller output_enable (level); its rising edge marks completion
//   busy                   high while a sum is in flight (GO or WAIT)
//   count                  words of the current set already accepted
//   error                  watchdog abort pulse
//
// Optional feature: define ADDER_LOADER_WATCHDOG_EN to build the WAIT watchdog.
// Without it error is constant 0 and WAIT is held until a done rising edge.

module adder_operand_loader #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             go,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] d_out,
  input  logic             done,
  output logic             busy,
  output logic [1:0]       count,
  output logic             error
);

  // Watchdog limits below 8 cycles would fire before a healthy controller can answer.
  if (TIMEOUT < 8) begin : g_bad_timeout
    $error("adder_operand_loader: TIMEOUT must be at least 8");
  end

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_GO      = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] stage0_q, stage0_d;
  logic [WIDTH-1:0] stage1_q, stage1_d;
  logic [WIDTH-1:0] stage2_q, stage2_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             go_q, go_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;
  logic             done_q;
  logic             xfer;
  logic             done_rise;

`ifdef ADDER_LOADER_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

  // Reset gates in_ready so nothing can be accepted during the reset cycle.
  assign in_ready  = (state_q == S_COLLECT) & ~rst;
  assign xfer      = in_valid & in_ready;
  // A done level carried over from the previous sum is not a completion.
  assign done_rise = done & ~done_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    stage0_d = stage0_q;
    stage1_d = stage1_q;
    stage2_d = stage2_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    go_d     = 1'b0;
    error_d  = 1'b0;
`ifdef ADDER_LOADER_WATCHDOG_EN
    wd_cnt_d = wd_cnt_q;
`endif

    case (state_q)
      S_COLLECT: begin
        if (xfer) begin
          count_d = count_q + 2'd1;  // wraps 3 -> 0 on the 4th word
          case (count_q)
            2'd0: stage0_d = in_data;
            2'd1: stage1_d = in_data;
            2'd2: stage2_d = in_data;
            default: begin
              // Whole set lands at once so the controller never sees a mixed set.
              a_d     = stage0_q;
              b_d     = stage1_q;
              c_d     = stage2_q;
              d_d     = in_data;
              go_d    = 1'b1;
              state_d = S_GO;
            end
          endcase
        end
      end
      S_GO: begin
        state_d = S_WAIT;
`ifdef ADDER_LOADER_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        // Completion takes priority over a coincident watchdog expiry.
        if (done_rise) begin
          state_d = S_COLLECT;
        end
`ifdef ADDER_LOADER_WATCHDOG_EN
        else if (wd_cnt_q == WD_LAST) begin
          error_d = 1'b1;
          state_d = S_COLLECT;
          count_d = 2'd0;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_COLLECT;
    endcase

    busy_d = (state_d != S_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_COLLECT;
      count_q  <= 2'd0;
      stage0_q <= '0;
      stage1_q <= '0;
      stage2_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef ADDER_LOADER_WATCHDOG_EN
      wd_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      stage0_q <= stage0_d;
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
      done_q   <= done;
`ifdef ADDER_LOADER_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
`endif
    end
  end

  assign go    = go_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign error = error_q;
  assign a_out = a_q;
  assign b_out = b_q;
  assign c_out = c_q;
  assign d_out = d_q;

endmodule
